// File: rtl/riscv_div_arb.sv
// Round-robin arbiter and sequencer that shares one iterative riscv_div between two requesters.
// Issues a single-cycle start pulse, returns the result to the owner and recovers a hung divider.
module riscv_div_arb #(
    parameter int unsigned TIMEOUT = 48
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] opcode0,
    input  logic [31:0] opcode1,
    input  logic [31:0] ra0,
    input  logic [31:0] ra1,
    input  logic [31:0] rb0,
    input  logic [31:0] rb1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        resp_valid0,
    output logic        resp_valid1,
    output logic [31:0] resp_result0,
    output logic [31:0] resp_result1,
    output logic        resp_err0,
    output logic        resp_err1,
    output logic        div_srst_n,
    output logic        div_valid,
    output logic [31:0] div_opcode,
    output logic [31:0] div_ra,
    output logic [31:0] div_rb,
    input  logic        div_done,
    input  logic [31:0] div_result
);

    localparam int unsigned CntW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StRecover} state_e;

    state_e      st_q, st_d;
    logic        rr_last_q, rr_last_d;
    logic        owner_q, owner_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic        div_valid_q, div_valid_d;
    logic [31:0] div_opcode_q, div_opcode_d;
    logic [31:0] div_ra_q, div_ra_d;
    logic [31:0] div_rb_q, div_rb_d;
    logic        resp_valid0_q, resp_valid0_d;
    logic        resp_valid1_q, resp_valid1_d;
    logic [31:0] resp_result0_q, resp_result0_d;
    logic [31:0] resp_result1_q, resp_result1_d;
    logic        resp_err0_q, resp_err0_d;
    logic        resp_err1_q, resp_err1_d;

    logic        pick1;
    logic [31:0] sel_op;
    logic        sel_legal;
    logic [31:0] res_next;
    logic        err_next;

    // On a tie the port that was not granted last wins.
    assign pick1     = req1 & (~req0 | ~rr_last_q);
    assign sel_op    = pick1 ? opcode1 : opcode0;
    assign sel_legal = (sel_op[6:0] == 7'b0110011) && (sel_op[31:25] == 7'b0000001) && sel_op[14];

    always_comb begin
        st_d           = st_q;
        rr_last_d      = rr_last_q;
        owner_d        = owner_q;
        cnt_d          = cnt_q;
        div_opcode_d   = div_opcode_q;
        div_ra_d       = div_ra_q;
        div_rb_d       = div_rb_q;
        div_valid_d    = 1'b0;
        resp_valid0_d  = 1'b0;
        resp_valid1_d  = 1'b0;
        resp_result0_d = '0;
        resp_result1_d = '0;
        resp_err0_d    = 1'b0;
        resp_err1_d    = 1'b0;
        res_next       = '0;
        err_next       = 1'b0;
        gnt0           = 1'b0;
        gnt1           = 1'b0;

        case (st_q)
            StIdle: begin
                if (!srst && (req0 || req1)) begin
                    gnt0         = ~pick1;
                    gnt1         = pick1;
                    owner_d      = pick1;
                    rr_last_d    = pick1;
                    div_opcode_d = sel_op;
                    div_ra_d     = pick1 ? ra1 : ra0;
                    div_rb_d     = pick1 ? rb1 : rb0;
                    if (sel_legal) begin
                        st_d        = StIssue;
                        div_valid_d = 1'b1;
                    end else begin
                        st_d     = StResp;
                        err_next = 1'b1;
                    end
                end
            end
            StIssue: begin
                cnt_d = '0;
                st_d  = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (div_done) begin
                    res_next = div_result;
                    st_d     = StResp;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    st_d = StRecover;
                end
            end
            StRecover: begin
                res_next = 32'hFFFF_FFFF;
                err_next = 1'b1;
                st_d     = StResp;
            end
            StResp: begin
                st_d = StIdle;
            end
            default: begin
                st_d = StIdle;
            end
        endcase

        // Response registers load on entry to RESP so the strobe lines up with that state.
        if (st_d == StResp && st_q != StResp) begin
            if (owner_d) begin
                resp_valid1_d  = 1'b1;
                resp_result1_d = res_next;
                resp_err1_d    = err_next;
            end else begin
                resp_valid0_d  = 1'b1;
                resp_result0_d = res_next;
                resp_err0_d    = err_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            st_q           <= StIdle;
            rr_last_q      <= 1'b1;
            owner_q        <= 1'b0;
            cnt_q          <= '0;
            div_valid_q    <= 1'b0;
            div_opcode_q   <= '0;
            div_ra_q       <= '0;
            div_rb_q       <= '0;
            resp_valid0_q  <= 1'b0;
            resp_valid1_q  <= 1'b0;
            resp_result0_q <= '0;
            resp_result1_q <= '0;
            resp_err0_q    <= 1'b0;
            resp_err1_q    <= 1'b0;
        end else begin
            st_q           <= st_d;
            rr_last_q      <= rr_last_d;
            owner_q        <= owner_d;
            cnt_q          <= cnt_d;
            div_valid_q    <= div_valid_d;
            div_opcode_q   <= div_opcode_d;
            div_ra_q       <= div_ra_d;
            div_rb_q       <= div_rb_d;
            resp_valid0_q  <= resp_valid0_d;
            resp_valid1_q  <= resp_valid1_d;
            resp_result0_q <= resp_result0_d;
            resp_result1_q <= resp_result1_d;
            resp_err0_q    <= resp_err0_d;
            resp_err1_q    <= resp_err1_d;
        end
    end

    assign div_srst_n   = ~srst & (st_q != StRecover);
    assign div_valid    = div_valid_q;
    assign div_opcode   = div_opcode_q;
    assign div_ra       = div_ra_q;
    assign div_rb       = div_rb_q;
    assign resp_valid0  = resp_valid0_q;
    assign resp_valid1  = resp_valid1_q;
    assign resp_result0 = resp_result0_q;
    assign resp_result1 = resp_result1_q;
    assign resp_err0    = resp_err0_q;
    assign resp_err1    = resp_err1_q;

endmodule

// File: tb/tb_riscv_div_arb.sv
// Bench for riscv_div_arb: behavioural divider stub, two requesters and a response scoreboard.
module tb_riscv_div_arb;

    localparam int unsigned Timeout = 48;

    logic        clk = 1'b0;
    logic        srst;
    logic        req0, req1;
    logic [31:0] opcode0, opcode1, ra0, ra1, rb0, rb1;
    logic        gnt0, gnt1;
    logic        resp_valid0, resp_valid1;
    logic [31:0] resp_result0, resp_result1;
    logic        resp_err0, resp_err1;
    logic        div_srst_n, div_valid;
    logic [31:0] div_opcode, div_ra, div_rb;
    logic        div_done;
    logic [31:0] div_result;

    riscv_div_arb #(.TIMEOUT(Timeout)) dut (
        .clk(clk), .srst(srst),
        .req0(req0), .req1(req1),
        .opcode0(opcode0), .opcode1(opcode1),
        .ra0(ra0), .ra1(ra1), .rb0(rb0), .rb1(rb1),
        .gnt0(gnt0), .gnt1(gnt1),
        .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
        .resp_result0(resp_result0), .resp_result1(resp_result1),
        .resp_err0(resp_err0), .resp_err1(resp_err1),
        .div_srst_n(div_srst_n), .div_valid(div_valid),
        .div_opcode(div_opcode), .div_ra(div_ra), .div_rb(div_rb),
        .div_done(div_done), .div_result(div_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] res;
        logic        err;
        int          lat;
        int          gcyc;
    } exp_t;

    exp_t sb_q[$];
    bit   gnt_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   resp_count = 0;
    int   dv_count = 0;
    int   rec_low = 0;
    int   gnt_cyc = 0;
    bit   busy = 1'b0;
    bit   dv_prev = 1'b0;
    bit   hang = 1'b0;
    bit   spurious = 1'b0;
    int   stub_lat = 2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk_op(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic bit is_legal(input logic [31:0] op);
        return (op[6:0] == 7'b0110011) && (op[31:25] == 7'b0000001) && op[14];
    endfunction

    // RISC-V M-extension division semantics, including divide-by-zero and overflow.
    function automatic logic [31:0] ref_div(input logic [31:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op[13:12])
            2'b00:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : $signed(a) / $signed(b);
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : ovf ? 32'h0 : $signed(a) % $signed(b);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Divider stub: done arrives stub_lat cycles after the valid cycle, never when hang is set.
    logic        stub_done = 1'b0;
    logic [31:0] stub_res = '0;
    int          stub_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!div_srst_n) begin
            stub_done <= 1'b0;
            stub_cnt  <= 0;
            stub_res  <= '0;
        end else begin
            stub_done <= 1'b0;
            if (div_valid && !hang) begin
                if (stub_lat <= 1) begin
                    stub_done <= 1'b1;
                    stub_res  <= ref_div(div_opcode, div_ra, div_rb);
                end else begin
                    stub_cnt <= stub_lat - 1;
                end
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) begin
                    stub_done <= 1'b1;
                    stub_res  <= ref_div(div_opcode, div_ra, div_rb);
                end
            end
        end
    end

    assign div_done   = stub_done | spurious;
    assign div_result = stub_res;

    // Monitor and scoreboard.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] op, a, b;
        int p;
        if (srst) begin
            sb_q.delete();
            busy    = 1'b0;
            dv_prev = 1'b0;
        end else begin
            if (gnt0 || gnt1) begin
                check("gnt_onehot", 32'(gnt0 & gnt1), 0);
                check("gnt_while_busy", 32'(busy), 0);
                p  = gnt1 ? 1 : 0;
                op = p ? opcode1 : opcode0;
                a  = p ? ra1 : ra0;
                b  = p ? rb1 : rb0;
                e.port = p;
                e.gcyc = cyc;
                if (!is_legal(op)) begin
                    e.res = 32'h0; e.err = 1'b1; e.lat = 1;
                end else if (hang) begin
                    e.res = 32'hFFFF_FFFF; e.err = 1'b1; e.lat = Timeout + 3;
                end else begin
                    e.res = ref_div(op, a, b); e.err = 1'b0; e.lat = stub_lat + 2;
                end
                sb_q.push_back(e);
                gnt_log.push_back(p[0]);
                gnt_cyc = cyc;
                busy    = 1'b1;
            end
            if (div_valid) begin
                check("div_valid_single", 32'(dv_prev), 0);
                dv_count++;
            end
            dv_prev = div_valid;
            if (!div_srst_n) begin
                rec_low++;
                check("recover_cycle", 32'(cyc - gnt_cyc), Timeout + 2);
            end
            if (resp_valid0 || resp_valid1) begin
                check("resp_onehot", 32'(resp_valid0 & resp_valid1), 0);
                if (sb_q.size() == 0) begin
                    check("resp_unexpected", 32'(resp_valid1), 32'(~resp_valid1));
                end else begin
                    e = sb_q.pop_front();
                    p = resp_valid1 ? 1 : 0;
                    check("resp_port", p, e.port);
                    check("resp_result", p ? resp_result1 : resp_result0, e.res);
                    check("resp_err", 32'(p ? resp_err1 : resp_err0), 32'(e.err));
                    check("resp_latency", 32'(cyc - e.gcyc), e.lat);
                    check("other_result", p ? resp_result0 : resp_result1, 0);
                    check("other_err", 32'(p ? resp_err0 : resp_err1), 0);
                end
                busy = 1'b0;
                resp_count++;
            end
        end
    end

    task automatic do_req(input int p, input logic [31:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int  t;
        int  rc0;
        bit  got;
        rc0 = resp_count;
        @(posedge clk) #1;
        if (p == 0) begin
            req0 = 1'b1; opcode0 = op; ra0 = a; rb0 = b;
        end else begin
            req1 = 1'b1; opcode1 = op; ra1 = a; rb1 = b;
        end
        t   = 0;
        got = 1'b0;
        while (!got && t < 20) begin
            @(negedge clk);
            got = (p == 0) ? gnt0 : gnt1;
            t++;
        end
        check("gnt_seen", 32'(got), 1);
        @(posedge clk) #1;
        req0 = 1'b0;
        req1 = 1'b0;
        t = 0;
        while (resp_count == rc0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        check("resp_seen", 32'(resp_count != rc0), 1);
    endtask

    initial begin
        int t;
        int dv0;
        int rc0;
        int rec0;
        srst = 1'b1;
        req0 = 1'b1; opcode0 = mk_op(3'b101); ra0 = 32'd10; rb0 = 32'd2;
        req1 = 1'b1; opcode1 = mk_op(3'b101); ra1 = 32'd9;  rb1 = 32'd3;
        stub_lat = 2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt0", 32'(gnt0), 0);
        check("rst_gnt1", 32'(gnt1), 0);
        check("rst_resp_valid", 32'({resp_valid0, resp_valid1}), 0);
        check("rst_div_valid", 32'(div_valid), 0);
        check("rst_div_opcode", div_opcode, 0);
        check("rst_div_ra", div_ra, 0);
        check("rst_resp_result", resp_result0 | resp_result1, 0);
        check("rst_div_srst_n", 32'(div_srst_n), 0);
        @(posedge clk) #1;
        srst = 1'b0;
        @(negedge clk);
        check("post_rst_div_srst_n", 32'(div_srst_n), 1);

        // Both ports held: grants must alternate starting with port 0.
        t = 0;
        while (resp_count < 4 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        check("rr_count", gnt_log.size(), 4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            check("rr_order", 32'(gnt_log[i]), 32'(i % 2));

        stub_lat = 3;
        dv0 = dv_count;
        do_req(0, mk_op(3'b101), 32'd100, 32'd7);
        check("divu_dv_pulses", dv_count - dv0, 1);

        stub_lat = 5;
        do_req(1, mk_op(3'b110), 32'hFFFF_FFF9, 32'd2);
        do_req(1, mk_op(3'b101), 32'd5, 32'd0);

        dv0 = dv_count;
        do_req(0, 32'h00B5_0533, 32'd1, 32'd2);
        check("illegal_dv_pulses", dv_count - dv0, 0);

        rc0 = resp_count;
        @(posedge clk) #1;
        spurious = 1'b1;
        @(posedge clk) #1;
        spurious = 1'b0;
        repeat (4) @(posedge clk);
        check("spurious_done_ignored", resp_count - rc0, 0);

        hang = 1'b1;
        rec0 = rec_low;
        do_req(1, mk_op(3'b101), 32'd7, 32'd3);
        check("recover_pulses", rec_low - rec0, 1);
        hang = 1'b0;

        // Reset in the middle of WAIT must drop the in-flight request silently.
        stub_lat = 20;
        rc0 = resp_count;
        @(posedge clk) #1;
        req0 = 1'b1; opcode0 = mk_op(3'b100); ra0 = 32'd50; rb0 = 32'd5;
        @(negedge clk);
        check("srst_test_gnt", 32'(gnt0), 1);
        @(posedge clk) #1;
        req0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        srst = 1'b1;
        @(posedge clk) #1;
        srst = 1'b0;
        @(negedge clk);
        check("srst_resp_valid", 32'({resp_valid0, resp_valid1}), 0);
        check("srst_div_valid", 32'(div_valid), 0);
        check("srst_div_opcode", div_opcode, 0);
        check("srst_div_rb", div_rb, 0);
        check("srst_div_srst_n", 32'(div_srst_n), 1);
        repeat (30) @(posedge clk);
        check("srst_no_resp", resp_count - rc0, 0);

        stub_lat = 4;
        do_req(0, mk_op(3'b100), 32'h8000_0000, 32'hFFFF_FFFF);

        for (int i = 0; i < 6; i++) begin
            stub_lat = $urandom_range(1, 6);
            do_req($urandom_range(0, 1), mk_op(3'($urandom_range(4, 7))), $urandom,
                   32'($urandom_range(0, 40)));
        end

        repeat (3) @(posedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
